// File: rtl/player_sprite_renderer_pkg.sv
// Shared types, constants and ROM content functions for the chef sprite renderer.
// Atlas and palette contents are generated patterns so the ROMs need no init file.
package overcooked_pkg;

  typedef enum logic [1:0] {
    P_LEFT  = 2'd0,
    P_RIGHT = 2'd1,
    P_UP    = 2'd2,
    P_DOWN  = 2'd3
  } dir_t;

  typedef enum logic [3:0] {
    P_NOTHING    = 4'd0,
    P_WALK       = 4'd1,
    P_HOLD_FOOD  = 4'd2,
    P_HOLD_PLATE = 4'd3,
    P_CHOP       = 4'd4,
    P_WASH       = 4'd5,
    P_STIR       = 4'd6,
    P_HOLD_POT   = 4'd7,
    P_SERVE      = 4'd8,
    P_EXT_OFF    = 4'd9,
    P_EXT_ON     = 4'd10
  } pstate_t;

  localparam int PLAYER_PIPE_LAT = 4;

  // Atlas colour index: low address byte xor'd with the sprite-frame number.
  function automatic logic [7:0] atlas_idx(input logic [31:0] addr, input int frame_px);
    logic [31:0] frame_num;
    frame_num = addr / 32'(frame_px);
    return addr[7:0] ^ frame_num[7:0];
  endfunction

  function automatic logic [7:0] pal_r(input logic [7:0] idx);
    return idx;
  endfunction

  function automatic logic [7:0] pal_g(input logic [7:0] idx);
    return ~idx;
  endfunction

  function automatic logic [7:0] pal_b(input logic [7:0] idx);
    return {idx[3:0], idx[7:4]};
  endfunction

endpackage

// File: rtl/player_sprite_renderer_if.sv
// Pixel-stream and per-player control bundle between the game FSM, renderer and pixel mux.
interface player_sprite_renderer_if #(
  parameter int NUM_PLAYERS = 2
);
  localparam int ID_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

  logic [10:0]               hcount_in;
  logic [9:0]                vcount_in;
  logic [NUM_PLAYERS*11-1:0] x_in;
  logic [NUM_PLAYERS*10-1:0] y_in;
  logic [NUM_PLAYERS*2-1:0]  player_direction;
  logic [NUM_PLAYERS*4-1:0]  player_state;
  logic [NUM_PLAYERS-1:0]    player_en_in;
  logic [11:0]               pixel_out;
  logic                      hit_out;
  logic [ID_W-1:0]           hit_id_out;

  modport master (
    output hcount_in, vcount_in, x_in, y_in, player_direction, player_state, player_en_in,
    input  pixel_out, hit_out, hit_id_out
  );

  modport slave (
    input  hcount_in, vcount_in, x_in, y_in, player_direction, player_state, player_en_in,
    output pixel_out, hit_out, hit_id_out
  );
endinterface

// File: rtl/player_sprite_renderer_sprite_lane.sv
// One player's lane: frame-latched shadows, box test, atlas address and atlas ROM.
// in_box/idx describe the pixel presented two cycles earlier.
module sprite_lane import overcooked_pkg::*; #(
  parameter int NUM_STATES  = 11,
  parameter int ANIM_FRAMES = 2,
  parameter int WIDTH       = 32,
  parameter int HEIGHT      = 32,
  parameter int FRAME_W     = 1
) (
  input  logic               pixel_clk_in,
  input  logic               rst_in,
  input  logic               frame_start,
  input  logic [FRAME_W-1:0] anim_frame,
  input  logic [10:0]        hcount,
  input  logic [9:0]         vcount,
  input  logic [10:0]        x,
  input  logic [9:0]         y,
  input  logic [1:0]         direction,
  input  logic [3:0]         state,
  input  logic               en,
  output logic               in_box,
  output logic [7:0]         idx
);
  localparam int ADDR_W = $clog2(NUM_STATES * 4 * ANIM_FRAMES * WIDTH * HEIGHT);
  localparam int DX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DY_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [10:0]       x_sh_r;
  logic [9:0]        y_sh_r;
  dir_t              dir_sh_r;
  logic [3:0]        st_sh_r;
  logic              en_sh_r;
  logic              shadow_valid_r;
  logic              box_s;
  logic [DX_W-1:0]   dx_s;
  logic [DY_W-1:0]   dy_s;
  pstate_t           st_eff_s;
  logic [ADDR_W-1:0] addr_s;
  logic              box1_r;
  logic              box2_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        idx_r;

  // Shadow registers only follow the inputs at frame start, so a frame never tears.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      x_sh_r         <= 11'd0;
      y_sh_r         <= 10'd0;
      dir_sh_r       <= P_LEFT;
      st_sh_r        <= 4'd0;
      en_sh_r        <= 1'b0;
      shadow_valid_r <= 1'b0;
    end else if (frame_start) begin
      x_sh_r         <= x;
      y_sh_r         <= y;
      dir_sh_r       <= dir_t'(direction);
      st_sh_r        <= state;
      en_sh_r        <= en;
      shadow_valid_r <= 1'b1;
    end
  end

  // Box test is widened by one bit so sprites near the right/bottom edge cannot wrap.
  always_comb begin
    box_s = ({1'b0, hcount} >= {1'b0, x_sh_r}) &&
            ({1'b0, hcount} <  ({1'b0, x_sh_r} + 12'(WIDTH))) &&
            ({1'b0, vcount} >= {1'b0, y_sh_r}) &&
            ({1'b0, vcount} <  ({1'b0, y_sh_r} + 11'(HEIGHT))) &&
            en_sh_r && shadow_valid_r;
    dx_s     = DX_W'(hcount - x_sh_r);
    dy_s     = DY_W'(vcount - y_sh_r);
    st_eff_s = (int'(st_sh_r) < NUM_STATES) ? pstate_t'(st_sh_r) : P_NOTHING;
    addr_s   = ((((ADDR_W'(st_eff_s) * ADDR_W'(3'd4) + ADDR_W'(dir_sh_r))
                * ADDR_W'(ANIM_FRAMES) + ADDR_W'(anim_frame))
                * ADDR_W'(HEIGHT) + ADDR_W'(dy_s))
                * ADDR_W'(WIDTH) + ADDR_W'(dx_s));
  end

  // Address stage followed by the one-cycle atlas ROM read.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      box1_r <= 1'b0;
      box2_r <= 1'b0;
      addr_r <= {ADDR_W{1'b0}};
      idx_r  <= 8'h00;
    end else begin
      box1_r <= box_s;
      addr_r <= addr_s;
      box2_r <= box1_r;
      idx_r  <= atlas_idx(32'(addr_r), WIDTH * HEIGHT);
    end
  end

  assign in_box = box2_r;
  assign idx    = idx_r;

endmodule

// File: rtl/player_sprite_renderer.sv
// Renders NUM_PLAYERS chef sprites over the pixel stream with a fixed 4-cycle latency.
// Lower player index wins overlapping opaque pixels; transparent pixels fall through.
module player_sprite_renderer import overcooked_pkg::*; #(
  parameter int         NUM_PLAYERS = 2,
  parameter int         WIDTH       = 32,
  parameter int         HEIGHT      = 32,
  parameter int         NUM_STATES  = 11,
  parameter int         ANIM_FRAMES = 2,
  parameter int         ANIM_DIV    = 8,
  parameter logic [7:0] TRANSP_IDX  = 8'h00
) (
  input logic                      pixel_clk_in,
  input logic                      rst_in,
  player_sprite_renderer_if.slave  bus
);
  localparam int ID_W    = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int FRAME_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam int DIV_W   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic                   frame_start_s;
  logic [DIV_W-1:0]       anim_div_cnt_r;
  logic [FRAME_W-1:0]     anim_frame_r;
  logic [NUM_PLAYERS-1:0] lane_box_s;
  logic [7:0]             lane_idx_s [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] opaque_s;
  logic                   win_hit_s;
  logic [ID_W-1:0]        win_id_s;
  logic [7:0]             win_idx_s;
  logic                   hit3_r;
  logic [ID_W-1:0]        id3_r;
  logic [7:0]             idx3_r;
  logic [7:0]             rcm_s;
  logic [7:0]             gcm_s;
  logic [7:0]             bcm_s;
  logic [11:0]            pixel_r;
  logic                   hit_r;
  logic [ID_W-1:0]        id_r;

  assign frame_start_s = (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);

  // Animation advances at frame start, so the new frame index applies to the frame just latched.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      anim_div_cnt_r <= {DIV_W{1'b0}};
      anim_frame_r   <= {FRAME_W{1'b0}};
    end else if (frame_start_s) begin
      if (int'(anim_div_cnt_r) == ANIM_DIV - 1) begin
        anim_div_cnt_r <= {DIV_W{1'b0}};
        anim_frame_r   <= (int'(anim_frame_r) == ANIM_FRAMES - 1) ? {FRAME_W{1'b0}}
                                                                  : anim_frame_r + FRAME_W'(1'b1);
      end else begin
        anim_div_cnt_r <= anim_div_cnt_r + DIV_W'(1'b1);
      end
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_lane
    sprite_lane #(
      .NUM_STATES  (NUM_STATES),
      .ANIM_FRAMES (ANIM_FRAMES),
      .WIDTH       (WIDTH),
      .HEIGHT      (HEIGHT),
      .FRAME_W     (FRAME_W)
    ) u_lane (
      .pixel_clk_in (pixel_clk_in),
      .rst_in       (rst_in),
      .frame_start  (frame_start_s),
      .anim_frame   (anim_frame_r),
      .hcount       (bus.hcount_in),
      .vcount       (bus.vcount_in),
      .x            (bus.x_in[p*11 +: 11]),
      .y            (bus.y_in[p*10 +: 10]),
      .direction    (bus.player_direction[p*2 +: 2]),
      .state        (bus.player_state[p*4 +: 4]),
      .en           (bus.player_en_in[p]),
      .in_box       (lane_box_s[p]),
      .idx          (lane_idx_s[p])
    );
    assign opaque_s[p] = lane_box_s[p] && (lane_idx_s[p] != TRANSP_IDX);
  end

  // Scanning from the top index down leaves the lowest opaque player as the winner.
  always_comb begin
    win_hit_s = 1'b0;
    win_id_s  = {ID_W{1'b0}};
    win_idx_s = 8'h00;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      win_hit_s = opaque_s[p] ? 1'b1          : win_hit_s;
      win_id_s  = opaque_s[p] ? ID_W'(p)      : win_id_s;
      win_idx_s = opaque_s[p] ? lane_idx_s[p] : win_idx_s;
    end
  end

  // Winner stage feeding the shared palette ROMs.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      hit3_r <= 1'b0;
      id3_r  <= {ID_W{1'b0}};
      idx3_r <= 8'h00;
    end else begin
      hit3_r <= win_hit_s;
      id3_r  <= win_id_s;
      idx3_r <= win_idx_s;
    end
  end

  assign rcm_s = pal_r(idx3_r);
  assign gcm_s = pal_g(idx3_r);
  assign bcm_s = pal_b(idx3_r);

  // Palette read and output register; everything is forced to zero on a miss.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      pixel_r <= 12'h000;
      hit_r   <= 1'b0;
      id_r    <= {ID_W{1'b0}};
    end else begin
      pixel_r <= hit3_r ? {rcm_s[7:4], gcm_s[7:4], bcm_s[7:4]} : 12'h000;
      hit_r   <= hit3_r;
      id_r    <= hit3_r ? id3_r : {ID_W{1'b0}};
    end
  end

  assign bus.pixel_out  = pixel_r;
  assign bus.hit_out    = hit_r;
  assign bus.hit_id_out = id_r;

endmodule
